control_multiciclo: RTL and testbench
=====================================

# control_multiciclo

Multi-cycle control unit for the RV32I core. It sequences fetch, decode, execute, memory and write-back around the combinational instruction decoder, register file, ALU and a single shared instruction/data memory port. It consumes the decoder's `opcode`/`funct3` plus instruction bit 30, and drives every datapath select and strobe. It also keeps a retired-instruction counter.

## Interface
- No parameters.
- `clk` in 1: core clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 7: decoder `opcode` output.
- `funct3` in 3: decoder `funct3` output.
- `funct7b5` in 1: instruction bit 30.
- `br_taken` in 1: branch comparator result for the current rs1/rs2/funct3.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request; held until `mem_ready`.
- `mem_we` out 1: request is a write.
- `mem_addr_sel` out 1: address source; 0 = PC, 1 = ALU result register.
- `ir_write` out 1: latch memory read data into the instruction register.
- `pc_write` out 1: update PC.
- `pc_src` out 2: next-PC source; 0 = PC+4, 1 = ALU result, 2 = ALU result & ~1.
- `alu_a_sel` out 2: ALU operand A; 0 = rs1, 1 = PC, 2 = zero.
- `alu_b_sel` out 1: ALU operand B; 0 = rs2, 1 = imm_out.
- `alu_op` out 4: ALU function `{sub_sra, funct3}`.
- `reg_write` out 1: register-file write enable.
- `wb_sel` out 2: write-back source; 0 = ALU, 1 = memory data, 2 = PC+4.
- `instret` out 32: retired-instruction count.
- `trap` out 1: illegal-instruction halt flag.
- `state` out 3: current state, for debug.

## Operation
- States:
  - FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
  - Strobes are combinational from state/opcode and forced to 0 while `reset`=1.
- FETCH:
  - Drives `mem_req`=1, `mem_addr_sel`=0.
  - On `mem_ready`: `ir_write`=1, go to DECODE. Otherwise stay.
- DECODE: one cycle, no strobes. Next state:
  - EXEC for opcodes 0110011, 0010011, 0110111, 0010111, 0000011, 0100011, 1100011, 1101111, 1100111.
  - Any other opcode is unknown (see Configuration).
- EXEC, by opcode:
  - R-type 0110011:
    - a=rs1, b=rs2, `alu_op`={funct7b5, funct3}.
    - Go to WB.
  - I-ALU 0010011:
    - a=rs1, b=imm.
    - `alu_op`={funct7b5 if funct3==101 else 0, funct3}.
    - Go to WB.
  - LUI: a=zero, b=imm, ADD, go to WB.
  - AUIPC: a=PC, b=imm, ADD, go to WB.
  - Load/store: a=rs1, b=imm, ADD, go to MEM.
  - Branch:
    - a=PC, b=imm, ADD.
    - `pc_write`=1, `pc_src`=`br_taken`?1:0.
    - Go to FETCH.
  - JAL:
    - a=PC, b=imm, ADD, `pc_src`=1.
    - `pc_write`=1, `reg_write`=1, `wb_sel`=2.
    - Go to FETCH.
  - JALR: same as JAL with a=rs1 and `pc_src`=2.
- MEM:
  - Drives `mem_req`=1, `mem_addr_sel`=1, `mem_we`=1 for stores.
  - Stays while `mem_ready`=0.
  - On `mem_ready`, load: go to WB.
  - On `mem_ready`, store: `pc_write`=1, `pc_src`=0, go to FETCH.
- WB:
  - `reg_write`=1, `pc_write`=1, `pc_src`=0.
  - `wb_sel`=1 for loads, 0 otherwise.
  - Go to FETCH.
- `instret`:
  - +1 on every cycle with `pc_write`=1.
  - Wraps from FFFFFFFF to 0.
- ADD encoding: `alu_op`=0000.
- `mem_ready` is ignored outside FETCH/MEM.

## Timing
- Reset values:
  - `state`=FETCH, `instret`=0, `trap`=0.
  - All strobes 0 during reset.
  - The first cycle after reset deasserts: `mem_req`=1.
- Latency with `mem_ready` returned in the same cycle as the request:
  - R/I/LUI/AUIPC: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch/JAL/JALR: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- Handshake rules:
  - `mem_req`, `mem_we` and `mem_addr_sel` stay stable until `mem_ready`.
  - `ir_write` pulses exactly in the `mem_ready` cycle of FETCH.
- Reset during MEM or FETCH: the request is abandoned and no strobe fires. The next cycle is FETCH from the current PC.
- `instret` and `pc_write` change in the same edge.

## Configuration
- `ILLEGAL_OP_TRAP_EN` defined:
  - An unknown opcode in DECODE goes to TRAP.
  - TRAP: `trap`=1, all strobes 0, `instret` frozen.
  - TRAP is left only by reset.
- `ILLEGAL_OP_TRAP_EN` undefined:
  - An unknown opcode is a NOP: DECODE asserts `pc_write`=1, `pc_src`=0, goes to FETCH, and `instret` increments.
  - `trap` is tied to 0 and TRAP is unreachable.

## Test plan
- `add` (0x002081B3), `mem_ready` always 1:
  - States go FETCH→DECODE→EXEC→WB.
  - EXEC: `alu_op`=0000.
  - WB: `reg_write`=1, `wb_sel`=0.
  - `instret` 0→1 after 4 cycles.
- `sub`/`srai`:
  - 0x40208233 → EXEC `alu_op`=1000.
  - 0x4020D213 → `alu_op`=1101.
  - `addi` with bit30=1 and funct3=000 → `alu_op`=0000.
- `lw` with `mem_ready` low for 3 cycles in MEM:
  - `mem_req`=1 and `mem_addr_sel`=1 held for 4 cycles.
  - Then WB with `wb_sel`=1.
  - Total 8 cycles.
- `beq` (0x00208463):
  - `br_taken`=1 → EXEC `pc_src`=1.
  - `br_taken`=0 → `pc_src`=0.
  - Both 3 cycles, `instret`+1.
- `jalr` → `pc_src`=2, `wb_sel`=2, `reg_write`=1 in EXEC. Reset asserted mid-MEM of `sw` → no `pc_write` and next state FETCH.
- Opcode 0x7F:
  - With the macro: TRAP, `trap`=1, `mem_req` stays 0 for 10 cycles.
  - Without the macro: NOP, `instret`+1 after 2 cycles.

Source files
------------

// File: rtl/control_multiciclo.sv
// rtl/control_multiciclo.sv - multi-cycle RV32I control FSM with retired-instruction counter
// Optional feature: ILLEGAL_OP_TRAP_EN (unknown opcodes halt in TRAP instead of retiring as NOP).
module control_multiciclo (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic [3:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [31:0] instret,
    output logic        trap,
    output logic [2:0]  state
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [2:0]  state_q, state_d;
    logic [31:0] instret_q, instret_d;
    logic        known_op;
    logic        is_store;

    assign is_store = (opcode == OP_STORE);

    always_comb begin
        known_op = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LOAD,
            OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: known_op = 1'b1;
            default:                              known_op = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        alu_a_sel    = 2'd0;
        alu_b_sel    = 1'b0;
        alu_op       = 4'b0000;
        reg_write    = 1'b0;
        wb_sel       = 2'd0;
        trap         = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (known_op) begin
                    state_d = S_EXEC;
                end else begin
`ifdef ILLEGAL_OP_TRAP_EN
                    state_d = S_TRAP;
`else
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_R: begin
                        alu_op  = {funct7b5, funct3};
                        state_d = S_WB;
                    end
                    OP_I: begin
                        // Only shifts (funct3=101) use bit 30 to pick SRAI over SRLI.
                        alu_b_sel = 1'b1;
                        alu_op    = {funct7b5 & (funct3 == 3'b101), funct3};
                        state_d   = S_WB;
                    end
                    OP_LUI: begin
                        alu_a_sel = 2'd2;
                        alu_b_sel = 1'b1;
                        state_d   = S_WB;
                    end
                    OP_AUIPC: begin
                        alu_a_sel = 2'd1;
                        alu_b_sel = 1'b1;
                        state_d   = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_b_sel = 1'b1;
                        state_d   = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_a_sel = 2'd1;
                        alu_b_sel = 1'b1;
                        pc_write  = 1'b1;
                        pc_src    = {1'b0, br_taken};
                    end
                    OP_JAL: begin
                        alu_a_sel = 2'd1;
                        alu_b_sel = 1'b1;
                        pc_write  = 1'b1;
                        pc_src    = 2'd1;
                        reg_write = 1'b1;
                        wb_sel    = 2'd2;
                    end
                    OP_JALR: begin
                        alu_b_sel = 1'b1;
                        pc_write  = 1'b1;
                        pc_src    = 2'd2;
                        reg_write = 1'b1;
                        wb_sel    = 2'd2;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d  = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                wb_sel    = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
                trap    = 1'b1;
                state_d = S_TRAP;
`else
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
        endcase
        // Reset abandons any in-flight request: nothing may strobe this cycle.
        if (reset) begin
            state_d      = S_FETCH;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            pc_src       = 2'd0;
            alu_a_sel    = 2'd0;
            alu_b_sel    = 1'b0;
            alu_op       = 4'b0000;
            reg_write    = 1'b0;
            wb_sel       = 2'd0;
            trap         = 1'b0;
        end
    end

    assign instret_d = pc_write ? instret_q + 32'd1 : instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign state   = state_q;
    assign instret = instret_q;
endmodule

// File: tb/tb_control_multiciclo.sv
// tb/tb_control_multiciclo.sv - directed scoreboard bench for control_multiciclo
module tb_control_multiciclo;
    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        br_taken;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
    logic [1:0]  pc_src, alu_a_sel, wb_sel;
    logic        alu_b_sel, reg_write, trap;
    logic [3:0]  alu_op;
    logic [31:0] instret;
    logic [2:0]  state;

    control_multiciclo dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .br_taken(br_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
        .reg_write(reg_write), .wb_sel(wb_sel), .instret(instret),
        .trap(trap), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [20:0] ctrl;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          nvec = 0;
    int          nmis = 0;
    logic [31:0] exp_instret = 32'd0;

    // {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_a_sel, alu_b_sel, alu_op, reg_write, wb_sel, trap}
    function automatic logic [20:0] pk(input logic [2:0] st, input logic mreq, input logic mwe,
                                       input logic masel, input logic irw, input logic pcw,
                                       input logic [1:0] pcs, input logic [1:0] asel, input logic bsel,
                                       input logic [3:0] op, input logic rw, input logic [1:0] wb,
                                       input logic trp);
        return {st, mreq, mwe, masel, irw, pcw, pcs, asel, bsel, op, rw, wb, trp};
    endfunction

    task automatic set_ins(input logic [31:0] ins);
        opcode   = ins[6:0];
        funct3   = ins[14:12];
        funct7b5 = ins[30];
    endtask

    task automatic step(input string tag, input logic rst, input logic rdy, input logic br,
                        input logic [20:0] ctrl);
        exp_t e;
        exp_t got;
        logic [20:0] obs;
        reset     = rst;
        mem_ready = rdy;
        br_taken  = br;
        e.tag  = tag;
        e.ctrl = ctrl;
        e.cnt  = exp_instret;
        sb.push_back(e);
        if (rst) exp_instret = 32'd0;
        else if (ctrl[13]) exp_instret = exp_instret + 32'd1;
        @(negedge clk);
        got = sb.pop_front();
        obs = {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_a_sel,
               alu_b_sel, alu_op, reg_write, wb_sel, trap};
        nvec++;
        assert (obs === got.ctrl) else begin
            nmis++;
            $error("FAIL %s ctrl observed=%h expected=%h", got.tag, obs, got.ctrl);
        end
        nvec++;
        assert (instret === got.cnt) else begin
            nmis++;
            $error("FAIL %s instret observed=%h expected=%h", got.tag, instret, got.cnt);
        end
        @(posedge clk);
        #1;
    endtask

    logic [20:0] F1, F0, DEC, WB0, WB1, ZERO;

    task automatic do_alu(input string tag, input logic [31:0] ins, input logic [1:0] asel,
                          input logic bsel, input logic [3:0] op);
        set_ins(ins);
        step({tag, "_fetch"}, 0, 1, 0, F1);
        step({tag, "_decode"}, 0, 1, 0, DEC);
        step({tag, "_exec"}, 0, 1, 0, pk(3'd2, 0, 0, 0, 0, 0, 2'd0, asel, bsel, op, 0, 2'd0, 0));
        step({tag, "_wb"}, 0, 1, 0, WB0);
    endtask

    task automatic do_ctl(input string tag, input logic [31:0] ins, input logic br,
                          input logic [20:0] exec);
        set_ins(ins);
        step({tag, "_fetch"}, 0, 1, br, F1);
        step({tag, "_decode"}, 0, 1, br, DEC);
        step({tag, "_exec"}, 0, 1, br, exec);
    endtask

    initial begin
        F1   = pk(3'd0, 1, 0, 0, 1, 0, 2'd0, 2'd0, 0, 4'd0, 0, 2'd0, 0);
        F0   = pk(3'd0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 4'd0, 0, 2'd0, 0);
        DEC  = pk(3'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 4'd0, 0, 2'd0, 0);
        WB0  = pk(3'd4, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 4'd0, 1, 2'd0, 0);
        WB1  = pk(3'd4, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 4'd0, 1, 2'd1, 0);
        ZERO = pk(3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 4'd0, 0, 2'd0, 0);
        reset = 1'b1; mem_ready = 1'b0; br_taken = 1'b0;
        set_ins(32'h0000_0013);
        @(posedge clk); #1;
        step("reset", 1, 1, 0, ZERO);

        do_alu("add",   32'h002081B3, 2'd0, 0, 4'b0000);
        do_alu("sub",   32'h40208233, 2'd0, 0, 4'b1000);
        do_alu("srai",  32'h4020D213, 2'd0, 1, 4'b1101);
        do_alu("addi",  32'h40000093, 2'd0, 1, 4'b0000);
        do_alu("lui",   32'h123450B7, 2'd2, 1, 4'b0000);
        do_alu("auipc", 32'h00000097, 2'd1, 1, 4'b0000);

        set_ins(32'h0000A103);
        step("lw_fetch", 0, 1, 0, F1);
        step("lw_decode", 0, 1, 0, DEC);
        step("lw_exec", 0, 1, 0, pk(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 4'd0, 0, 2'd0, 0));
        for (int i = 0; i < 3; i++)
            step("lw_memwait", 0, 0, 0, pk(3'd3, 1, 0, 1, 0, 0, 2'd0, 2'd0, 0, 4'd0, 0, 2'd0, 0));
        step("lw_memdone", 0, 1, 0, pk(3'd3, 1, 0, 1, 0, 0, 2'd0, 2'd0, 0, 4'd0, 0, 2'd0, 0));
        step("lw_wb", 0, 1, 0, WB1);

        set_ins(32'h0020A023);
        step("sw_fetchwait", 0, 0, 0, F0);
        step("sw_fetch", 0, 1, 0, F1);
        step("sw_decode", 0, 1, 0, DEC);
        step("sw_exec", 0, 1, 0, pk(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 4'd0, 0, 2'd0, 0));
        step("sw_mem", 0, 1, 0, pk(3'd3, 1, 1, 1, 0, 1, 2'd0, 2'd0, 0, 4'd0, 0, 2'd0, 0));

        do_ctl("beq_t", 32'h00208463, 1, pk(3'd2, 0, 0, 0, 0, 1, 2'd1, 2'd1, 1, 4'd0, 0, 2'd0, 0));
        do_ctl("beq_n", 32'h00208463, 0, pk(3'd2, 0, 0, 0, 0, 1, 2'd0, 2'd1, 1, 4'd0, 0, 2'd0, 0));
        do_ctl("jal",   32'h0000006F, 0, pk(3'd2, 0, 0, 0, 0, 1, 2'd1, 2'd1, 1, 4'd0, 1, 2'd2, 0));
        do_ctl("jalr",  32'h000080E7, 0, pk(3'd2, 0, 0, 0, 0, 1, 2'd2, 2'd0, 1, 4'd0, 1, 2'd2, 0));

        set_ins(32'h0020A023);
        step("swr_fetch", 0, 1, 0, F1);
        step("swr_decode", 0, 1, 0, DEC);
        step("swr_exec", 0, 1, 0, pk(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 4'd0, 0, 2'd0, 0));
        step("swr_memwait", 0, 0, 0, pk(3'd3, 1, 1, 1, 0, 0, 2'd0, 2'd0, 0, 4'd0, 0, 2'd0, 0));
        step("swr_reset", 1, 1, 0, pk(3'd3, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 4'd0, 0, 2'd0, 0));
        step("swr_refetch", 0, 0, 0, F0);

        set_ins(32'h0000007F);
        step("ill_fetch", 0, 1, 0, F1);
`ifdef ILLEGAL_OP_TRAP_EN
        step("ill_decode", 0, 1, 0, DEC);
        for (int i = 0; i < 10; i++)
            step("ill_trap", 0, 1, 0, pk(3'd5, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 4'd0, 0, 2'd0, 1));
        step("ill_reset", 1, 1, 0, pk(3'd5, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 4'd0, 0, 2'd0, 0));
`else
        step("ill_nop", 0, 1, 0, pk(3'd1, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 4'd0, 0, 2'd0, 0));
`endif
        do_alu("add2", 32'h002081B3, 2'd0, 0, 4'b0000);
        step("final_fetch", 0, 0, 0, F0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
